// File: rtl/firram36_i_if.sv
// firram36_i_if -- write/read bus of the FIR sample-history RAM.
// The master side drives the write and read requests. The slave side (the RAM)
// returns the read word and the ready flag.
interface firram36_i_if #(
  parameter int WIDTH = 36,
  parameter int AW    = 6
);
  logic [WIDTH-1:0] data;
  logic [AW-1:0]    rdaddress;
  logic [AW-1:0]    wraddress;
  logic             wren;
  logic [WIDTH-1:0] q;
  logic             ready;

  modport master (
    output data, rdaddress, wraddress, wren,
    input  q, ready
  );

  modport slave (
    input  data, rdaddress, wraddress, wren,
    output q, ready
  );
endinterface

// File: rtl/firram36_i.sv
// firram36_i -- simple dual-port sample-history RAM for the interpolate-by-8 FIR.
// Each word is {I[17:0], Q[17:0]}. After every reset the block zeroes all
// locations, one per clock, before it raises ready.
// Optional macro FIRRAM_OUTREG_EN adds an output register, which gives a
// read latency of 2 cycles instead of 1.
module firram36_i #(
  parameter int WIDTH   = 36,
  parameter int AW      = 6,
  parameter int RDW_NEW = 0
) (
  input  logic        clock,
  input  logic        reset,
  firram36_i_if.slave bus
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [AW-1:0]    r_clrCount;
  logic [AW-1:0]    w_nextClrCount;
  logic             w_memWe;
  logic [AW-1:0]    w_memAddr;
  logic [WIDTH-1:0] w_memData;
  logic             w_rdBypass;
  logic [WIDTH-1:0] r_rdData;
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Clear-sweep state and counter. Reset restarts the sweep from address 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_CLEAR;
      r_clrCount <= '0;
    end else begin
      r_state    <= w_nextState;
      r_clrCount <= w_nextClrCount;
    end
  end

  // The sweep owns the write port until it is done. User writes are accepted
  // only once ready is high. During reset nothing is written.
  always_comb begin
    w_nextState    = r_state;
    w_nextClrCount = r_clrCount;
    w_memWe        = 1'b0;
    w_memAddr      = bus.wraddress;
    w_memData      = bus.data;
    w_rdBypass     = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_memWe        = !reset;
        w_memAddr      = r_clrCount;
        w_memData      = '0;
        w_nextClrCount = r_clrCount + 1'b1;
        if (r_clrCount == {AW{1'b1}}) begin
          w_nextState = ST_READY;
        end
      end
      ST_READY: begin
        w_memWe    = bus.wren && !reset;
        w_rdBypass = (RDW_NEW != 0) && w_memWe && (bus.wraddress == bus.rdaddress);
      end
      default: begin
        w_nextState = ST_CLEAR;
      end
    endcase
  end

  // Storage array. It has no reset; the clear sweep gives it a known value.
  always_ff @(posedge clock) begin
    if (w_memWe) begin
      r_mem[w_memAddr] <= w_memData;
    end
  end

  // The read stage samples the array at the presented address on every edge.
  // This gives 1-cycle latency, and by default old data on a read-during-write.
  // The stage is held at zero while the sweep runs.
  always_ff @(posedge clock) begin
    if (reset || r_state != ST_READY) begin
      r_rdData <= '0;
    end else if (w_rdBypass) begin
      r_rdData <= bus.data;
    end else begin
      r_rdData <= r_mem[bus.rdaddress];
    end
  end

`ifdef FIRRAM_OUTREG_EN
  logic [WIDTH-1:0] r_outData;

  // Extra output pipeline stage, also forced to zero until the RAM is ready.
  always_ff @(posedge clock) begin
    if (reset || r_state != ST_READY) begin
      r_outData <= '0;
    end else begin
      r_outData <= r_rdData;
    end
  end

  assign bus.q = r_outData;
`else
  assign bus.q = r_rdData;
`endif

  assign bus.ready = (r_state == ST_READY);

endmodule

// File: tb/tb_firram36_i.sv
// tb_firram36_i -- directed self-checking bench for firram36_i.
// Each scenario task drives its stimulus and compares the outputs in place.
module tb_firram36_i;

`ifdef FIRRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int RDW_NEW = 0;

  logic clock;
  logic reset;
  int   testsRun;
  int   testsFailed;

  firram36_i_if #(.WIDTH(36), .AW(6)) bus ();

  firram36_i #(.WIDTH(36), .AW(6), .RDW_NEW(RDW_NEW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] wa, input logic [35:0] wd,
                               input logic we, input logic [5:0] ra);
    bus.wraddress = wa;
    bus.data      = wd;
    bus.wren      = we;
    bus.rdaddress = ra;
    tick();
  endtask

  // Reset, then ready must stay low for 63 edges and be high after the 64th.
  // Every location must then read zero.
  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(6'd0, 36'd0, 1'b0, 6'd0);
    tick();
    testsRun++;
    if (bus.ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ready got %b want 0", bus.ready);
    end
    testsRun++;
    if (bus.q !== 36'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_q got %h want 0", bus.q);
    end
    reset = 1'b0;
    for (int i = 1; i <= 63; i++) begin
      tick();
      testsRun++;
      if (bus.ready !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL sweep_ready edge %0d got %b want 0", i, bus.ready);
      end
    end
    tick();
    testsRun++;
    if (bus.ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL ready_after_64 got %b want 1", bus.ready);
    end
    for (int i = 0; i < 64 + LAT - 1; i++) begin
      if (i < 64) bus.rdaddress = 6'(i);
      tick();
      if (i >= LAT - 1) begin
        testsRun++;
        if (bus.q !== 36'd0) begin
          testsFailed++;
          $display("[TB] FAIL clear_read addr %0d got %h want 0", i - LAT + 1, bus.q);
        end
      end
    end
  endtask

  // Write one word, then read it back. It must appear exactly LAT edges later.
  task automatic test_write_read();
    logic [35:0] want;
    applyStimulus(6'd5, 36'h1_2345_6789, 1'b1, 6'd0);
    bus.wren      = 1'b0;
    bus.rdaddress = 6'd5;
    for (int k = 0; k <= LAT; k++) begin
      if (k > 0) tick();
      want = (k == LAT) ? 36'h1_2345_6789 : 36'd0;
      testsRun++;
      if (bus.q !== want) begin
        testsFailed++;
        $display("[TB] FAIL write_read k=%0d got %h want %h", k, bus.q, want);
      end
    end
  endtask

  // Fill with n*3, then stream a descending read through the 0 -> 63 wrap.
  task automatic test_stream_wrap();
    logic [5:0]  addrs [13];
    logic [35:0] exps  [13];
    for (int n = 0; n < 64; n++) applyStimulus(6'(n), 36'(n * 3), 1'b1, 6'd0);
    bus.wren = 1'b0;
    for (int i = 0; i < 13; i++) begin
      addrs[i] = 6'(10 - i);
      exps[i]  = 36'(addrs[i]) * 36'd3;
    end
    for (int i = 0; i < 13 + LAT - 1; i++) begin
      if (i < 13) bus.rdaddress = addrs[i];
      tick();
      if (i >= LAT - 1) begin
        testsRun++;
        if (bus.q !== exps[i - LAT + 1]) begin
          testsFailed++;
          $display("[TB] FAIL stream idx %0d got %0d want %0d", i - LAT + 1, bus.q, exps[i - LAT + 1]);
        end
      end
    end
  endtask

  // Read-during-write to the same address.
  task automatic test_rdw();
    logic [35:0] want;
    applyStimulus(6'd7, 36'hA, 1'b1, 6'd0);
    applyStimulus(6'd7, 36'hB, 1'b1, 6'd7);
    bus.wren = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    want = (RDW_NEW != 0) ? 36'hB : 36'hA;
    testsRun++;
    if (bus.q !== want) begin
      testsFailed++;
      $display("[TB] FAIL rdw_same_edge got %h want %h", bus.q, want);
    end
    tick();
    testsRun++;
    if (bus.q !== 36'hB) begin
      testsFailed++;
      $display("[TB] FAIL rdw_next_read got %h want b", bus.q);
    end
  endtask

  // Reset 30 cycles into a sweep while hammering address 3 with writes.
  // The sweep must restart, and the writes must be ignored.
  task automatic test_reset_midsweep();
    int cycles;
    reset = 1'b1;
    applyStimulus(6'd3, 36'hF, 1'b1, 6'd3);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    testsRun++;
    if (bus.ready !== 1'b0 || bus.q !== 36'd0) begin
      testsFailed++;
      $display("[TB] FAIL midsweep_state got ready=%b q=%h want ready=0 q=0", bus.ready, bus.q);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cycles = 0;
    while (cycles < 200) begin
      tick();
      cycles++;
      if (bus.ready === 1'b1) break;
    end
    bus.wren = 1'b0;
    testsRun++;
    if (cycles != 64 || bus.ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midsweep_restart got %0d cycles want 64", cycles);
    end
    bus.rdaddress = 6'd3;
    for (int k = 0; k < LAT; k++) tick();
    testsRun++;
    if (bus.q !== 36'd0) begin
      testsFailed++;
      $display("[TB] FAIL ignored_write got %h want 0", bus.q);
    end
  endtask

  // Reset while ready with nonzero contents: q and ready must be low during
  // the sweep, and afterwards everything must read zero.
  task automatic test_reset_when_ready();
    int cycles;
    applyStimulus(6'd10, 36'h55, 1'b1, 6'd0);
    applyStimulus(6'd20, 36'h66, 1'b1, 6'd10);
    bus.wren = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    testsRun++;
    if (bus.q !== 36'h55) begin
      testsFailed++;
      $display("[TB] FAIL preload got %h want 55", bus.q);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cycles = 0;
    while (cycles < 200) begin
      testsRun++;
      if (bus.ready !== 1'b0 || bus.q !== 36'd0) begin
        testsFailed++;
        $display("[TB] FAIL resweep_out cycle %0d got ready=%b q=%h want 0/0", cycles, bus.ready, bus.q);
      end
      tick();
      cycles++;
      if (bus.ready === 1'b1) break;
    end
    testsRun++;
    if (cycles != 64) begin
      testsFailed++;
      $display("[TB] FAIL resweep_len got %0d want 64", cycles);
    end
    for (int i = 0; i < 64 + LAT - 1; i++) begin
      if (i < 64) bus.rdaddress = 6'(i);
      tick();
      if (i >= LAT - 1) begin
        testsRun++;
        if (bus.q !== 36'd0) begin
          testsFailed++;
          $display("[TB] FAIL recleared addr %0d got %h want 0", i - LAT + 1, bus.q);
        end
      end
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    bus.data      = '0;
    bus.wraddress = '0;
    bus.rdaddress = '0;
    bus.wren      = 1'b0;
    test_reset();
    test_write_read();
    test_stream_wrap();
    test_rdw();
    test_reset_midsweep();
    test_reset_when_ready();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/firram36_i.md
Name: firram36_i

Overview:
- Simple dual-port sample-history RAM for the interpolate-by-8 FIR: one write port, one read port, one clock.
- Each 36-bit word holds one complex sample as {I[17:0], Q[17:0]} (16-bit values sign-extended to 18 bits by the writer).
- Default geometry is 64 words × 36 bits, enough for NTAPS/8 = 64 history samples.
- On reset the block sweeps all locations to zero, so filter history starts silent.

Parameters:
- WIDTH, 36, data word width in bits.
- AW, 6, address width in bits; depth = 2^AW words.
- RDW_NEW, 0, read-during-write to the same address: 0 returns old data, 1 returns new data.

Ports:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- data  in  WIDTH  write data.
- rdaddress  in  AW  read address.
- wraddress  in  AW  write address.
- wren  in  1  write enable.
- q  out  WIDTH  read data.
- ready  out  1  high when the clear sweep is finished and the RAM is usable.

Behaviour:
- Storage: 2^AW × WIDTH array; no byte enables.
- Write: on a clock edge with wren=1 and ready=1, mem[wraddress] <= data.
  - wren while ready=0 is ignored.
- Read address path: rdaddress is registered every edge, regardless of ready.
- Read data: q = mem[registered rdaddress], so q reflects the address presented one edge earlier (1-cycle latency).
  - Consecutive addresses stream one word per cycle with no bubbles.
- Read-during-write to the same address on the same edge:
  - RDW_NEW=0: q shows the pre-write contents.
  - RDW_NEW=1: q shows the written data.
  - Different addresses never interact.
- Reset on any edge with reset=1:
  - ready <= 0.
  - Clear counter <= 0.
  - Registered read address <= 0.
  - q is forced to 0 from the next edge until ready rises.
- Clear sweep: starts on the first edge with reset=0 after reset.
  - One location zeroed per clock, addresses 0 .. 2^AW−1 in order.
  - ready <= 1 on the edge that writes the last address, so ready is high 2^AW cycles after reset deassertion (64 cycles at default).
- Reset asserted mid-sweep restarts the sweep from address 0.
- Reset asserted while ready=1 also re-clears all contents.
- Address wrap-around is natural modulo 2^AW. The writer increments wraddress and the reader decrements rdaddress through 0 → 2^AW−1; no special handling.
- Power-up without reset: contents undefined, ready=0 (initial value). The block is usable only after one reset.
- No other state; no flags for full/empty (the circular-buffer policy belongs to the owner FSM).

Optional Feature:
- Macro FIRRAM_OUTREG_EN.
- Defined: an extra output register follows the array read.
  - q latency becomes 2 cycles from rdaddress.
  - The output register is cleared by reset and held at 0 while ready=0.
  - Read-during-write semantics apply to the array-read stage.
- Not defined: 1-cycle latency as above.
- The FIR owner must add one pipeline-priming state when the macro is enabled.

Test Plan:
- Reset 1 cycle, then hold reset=0:
  - ready stays 0 for 63 edges and is 1 after the 64th.
  - Read all 64 addresses → every q = 0.
- After ready, write data=36'h1_2345_6789 to address 5, then rdaddress=5 → q = 36'h1_2345_6789 exactly one edge after the address is applied (two with FIRRAM_OUTREG_EN).
- Write address n with value n*3 for n=0..63, then read a descending stream 10, 9, …, 0, 63, 62 → q follows one cycle behind with values 30, 27, …, 0, 189, 186; no gaps at the wrap.
- Address 7 holds 36'hA; same-edge write 36'hB to address 7 with rdaddress=7:
  - RDW_NEW=0 → q = 36'hA, then 36'hB on the next read.
  - RDW_NEW=1 → q = 36'hB.
- Assert reset at cycle 30 of the sweep → ready rises 64 cycles after the new deassertion. wren=1 with data=36'hF at address 3 during the sweep is ignored: address 3 reads 0.
- With ready=1 and nonzero contents, pulse reset → q = 0 and ready = 0 during the sweep; all locations read 0 afterwards.
